// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: serialises one LSB load/store into byte accesses on a byte-wide RAM.
// Latency: accept at A, read ack at A+n+2, write ack at A+n+1 (n = 1/2/4 bytes); en=0 stretches it.
// Backpressure: single outstanding request; busy_o high outside IDLE, en=0 freezes all state.
module data_mem_ctrl #(
    parameter int ADR_W = 17,
    parameter int DAT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             lsb_en_i,
    input  logic             lsb_rwen_i,
    input  logic [2:0]       lsb_len_i,
    input  logic [ADR_W-1:0] lsb_adr_i,
    input  logic [DAT_W-1:0] lsb_dat_i,
    output logic             lsb_en_o,
    output logic [DAT_W-1:0] lsb_dat_o,
    output logic             busy_o,
    input  logic             rob_br_flag,
    output logic [ADR_W-1:0] ram_adr_o,
    output logic             ram_wr_o,
    output logic [7:0]       ram_dat_o,
    input  logic [7:0]       ram_dat_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADR_W-1:0]   base_q, base_d;
    logic [2:0]         nbytes_q, nbytes_d;     // 1, 2 or 4
    logic [DAT_W-1:0]   wdat_q, wdat_d;
    logic [2:0]         iss_q, iss_d;           // bytes issued to the RAM so far
    logic [1:0]         cap_q, cap_d;           // next byte lane to capture
    logic               bus_vld_q, bus_vld_d;   // a read address is on the RAM bus this cycle
    logic               rd_vld_q, rd_vld_d;     // ram_dat_i holds a byte we asked for
    logic [DAT_W-1:0]   rdat_q, rdat_d;
    logic [ADR_W-1:0]   ram_adr_q, ram_adr_d;
    logic               ram_wr_q, ram_wr_d;
    logic [7:0]         ram_dat_q, ram_dat_d;
    logic               lsb_en_q, lsb_en_d;
    logic [2:0]         len_dec;

    // Byte k of the store word (little-endian).
    function automatic logic [7:0] pick_byte(input logic [DAT_W-1:0] d, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return b;
    endfunction

    // Length decode as a byte count; an illegal zero length is treated as a single byte.
    always_comb begin
        len_dec = {lsb_len_i[2],
                   ~lsb_len_i[2] & lsb_len_i[1],
                   ~lsb_len_i[2] & ~lsb_len_i[1] & (lsb_len_i[0] | (lsb_len_i == 3'd0))};
    end

    // State register; en=0 holds everything, reset wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            nbytes_q  <= 3'd0;
            wdat_q    <= '0;
            iss_q     <= 3'd0;
            cap_q     <= 2'd0;
            bus_vld_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rdat_q    <= '0;
            ram_adr_q <= '0;
            ram_wr_q  <= 1'b0;
            ram_dat_q <= 8'd0;
            lsb_en_q  <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            base_q    <= base_d;
            nbytes_q  <= nbytes_d;
            wdat_q    <= wdat_d;
            iss_q     <= iss_d;
            cap_q     <= cap_d;
            bus_vld_q <= bus_vld_d;
            rd_vld_q  <= rd_vld_d;
            rdat_q    <= rdat_d;
            ram_adr_q <= ram_adr_d;
            ram_wr_q  <= ram_wr_d;
            ram_dat_q <= ram_dat_d;
            lsb_en_q  <= lsb_en_d;
        end
    end

    // Next-state and registered-output logic for the request sequencer.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nbytes_d  = nbytes_q;
        wdat_d    = wdat_q;
        iss_d     = iss_q;
        cap_d     = cap_q;
        bus_vld_d = 1'b0;
        rd_vld_d  = 1'b0;
        rdat_d    = rdat_q;
        ram_adr_d = ram_adr_q;
        ram_wr_d  = 1'b0;
        ram_dat_d = ram_dat_q;
        lsb_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A flushed read is dropped; a store is already committed and goes ahead.
                if (lsb_en_i && (lsb_rwen_i || !rob_br_flag)) begin
                    base_d    = lsb_adr_i;
                    nbytes_d  = len_dec;
                    wdat_d    = lsb_dat_i;
                    iss_d     = 3'd1;
                    cap_d     = 2'd0;
                    rdat_d    = '0;
                    ram_adr_d = lsb_adr_i;
                    if (lsb_rwen_i) begin
                        ram_dat_d = lsb_dat_i[7:0];
                        ram_wr_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        bus_vld_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end

            READ: begin
                if (rob_br_flag) begin
                    state_d = IDLE;
                end else begin
                    if (iss_q < nbytes_q) begin
                        ram_adr_d = base_q + ADR_W'(iss_q);
                        iss_d     = iss_q + 3'd1;
                        bus_vld_d = 1'b1;
                    end
                    rd_vld_d = bus_vld_q;
                    if (rd_vld_q) begin
                        case (cap_q)
                            2'd0:    rdat_d[7:0]   = ram_dat_i;
                            2'd1:    rdat_d[15:8]  = ram_dat_i;
                            2'd2:    rdat_d[23:16] = ram_dat_i;
                            default: rdat_d[31:24] = ram_dat_i;
                        endcase
                        cap_d = cap_q + 2'd1;
                        if ({1'b0, cap_q} == nbytes_q - 3'd1) begin
                            state_d  = DONE;
                            lsb_en_d = 1'b1;
                        end
                    end
                end
            end

            WRITE: begin
                if (iss_q < nbytes_q) begin
                    ram_adr_d = base_q + ADR_W'(iss_q);
                    ram_dat_d = pick_byte(wdat_q, iss_q[1:0]);
                    ram_wr_d  = 1'b1;
                    iss_d     = iss_q + 3'd1;
                end else begin
                    state_d  = DONE;
                    lsb_en_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: registered, with en gating the two strobes combinationally.
    always_comb begin
        lsb_en_o  = lsb_en_q & en;
        lsb_dat_o = rdat_q;
        busy_o    = (state_q != IDLE);
        ram_adr_o = ram_adr_q;
        ram_wr_o  = ram_wr_q & en;
        ram_dat_o = ram_dat_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int ADR_W = 17;
    localparam int DAT_W = 32;

    logic             clk = 1'b0;
    logic             rst, en;
    logic             lsb_en_i, lsb_rwen_i;
    logic [2:0]       lsb_len_i;
    logic [ADR_W-1:0] lsb_adr_i;
    logic [DAT_W-1:0] lsb_dat_i;
    logic             lsb_en_o;
    logic [DAT_W-1:0] lsb_dat_o;
    logic             busy_o;
    logic             rob_br_flag;
    logic [ADR_W-1:0] ram_adr_o;
    logic             ram_wr_o;
    logic [7:0]       ram_dat_o;
    logic [7:0]       ram_dat_i;

    data_mem_ctrl #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .lsb_en_i(lsb_en_i), .lsb_rwen_i(lsb_rwen_i), .lsb_len_i(lsb_len_i),
        .lsb_adr_i(lsb_adr_i), .lsb_dat_i(lsb_dat_i),
        .lsb_en_o(lsb_en_o), .lsb_dat_o(lsb_dat_o), .busy_o(busy_o),
        .rob_br_flag(rob_br_flag),
        .ram_adr_o(ram_adr_o), .ram_wr_o(ram_wr_o), .ram_dat_o(ram_dat_o),
        .ram_dat_i(ram_dat_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide RAM, one-cycle read latency, frozen by en.
    logic [7:0] mem [0:(1<<ADR_W)-1];
    always @(posedge clk) begin
        if (en) begin
            if (ram_wr_o) mem[ram_adr_o] <= ram_dat_o;
            ram_dat_i <= mem[ram_adr_o];
        end
    end

    typedef struct {
        logic [31:0] dat;
        logic        chk_dat;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [16:0] adr;
        logic [7:0]  dat;
    } wrec_t;

    typedef struct {
        logic        rwen;
        logic [2:0]  len;
        logic [16:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        int          lat;
    } vec_t;

    exp_t  sb[$];
    wrec_t wlog[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard pops on each ack, write log, write-strobe sanity.
    logic        prev_wr = 1'b0;
    logic [16:0] prev_adr = '0;
    always @(negedge clk) begin
        exp_t e;
        if (lsb_en_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got lsb_en_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                if (e.chk_dat) chk("load_data", lsb_dat_o, e.dat);
            end
        end
        if (ram_wr_o) begin
            wlog.push_back('{cyc, ram_adr_o, ram_dat_o});
            chk("wr_while_busy", {31'd0, busy_o}, 32'd1);
            if (prev_wr) chk("wr_repeat_adr", {31'd0, ram_adr_o == prev_adr}, 32'd0);
        end
        prev_wr  = ram_wr_o;
        prev_adr = ram_adr_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rwen, input logic [2:0] len, input logic [16:0] adr,
                         input logic [31:0] wdat, output int a);
        lsb_en_i   = 1'b1;
        lsb_rwen_i = rwen;
        lsb_len_i  = len;
        lsb_adr_i  = adr;
        lsb_dat_i  = wdat;
        a          = cyc;
        tick();
        lsb_en_i   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("ack_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    function automatic logic [31:0] mem_word(input logic [16:0] a);
        return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   a, a0, wc0, nstall;

        vecs[0]  = '{1'b1, 3'd4, 17'h00100, 32'hDEADBEEF, 32'h0,        5};
        vecs[1]  = '{1'b0, 3'd4, 17'h00100, 32'h0,        32'hDEADBEEF, 6};
        vecs[2]  = '{1'b0, 3'd2, 17'h00102, 32'h0,        32'h0000DEAD, 4};
        vecs[3]  = '{1'b0, 3'd1, 17'h00103, 32'h0,        32'h000000DE, 3};
        vecs[4]  = '{1'b1, 3'd4, 17'h1FFFE, 32'h11223344, 32'h0,        5};
        vecs[5]  = '{1'b0, 3'd4, 17'h1FFFE, 32'h0,        32'h11223344, 6};
        vecs[6]  = '{1'b0, 3'd1, 17'h00000, 32'h0,        32'h00000022, 3};
        vecs[7]  = '{1'b0, 3'd3, 17'h1FFFF, 32'h0,        32'h00002233, 4};
        vecs[8]  = '{1'b1, 3'd2, 17'h00200, 32'hAAAA5566, 32'h0,        3};
        vecs[9]  = '{1'b0, 3'd2, 17'h00200, 32'h0,        32'h00005566, 4};
        vecs[10] = '{1'b1, 3'd2, 17'h00202, 32'h99997788, 32'h0,        3};
        vecs[11] = '{1'b0, 3'd6, 17'h00200, 32'h0,        32'h77885566, 6};

        rst = 1'b1; en = 1'b1; lsb_en_i = 1'b0; lsb_rwen_i = 1'b0; lsb_len_i = 3'd0;
        lsb_adr_i = '0; lsb_dat_i = '0; rob_br_flag = 1'b0;
        tick(); tick(); tick();
        chk("rst_lsb_en_o",  {31'd0, lsb_en_o}, 32'd0);
        chk("rst_lsb_dat_o", lsb_dat_o, 32'd0);
        chk("rst_busy_o",    {31'd0, busy_o}, 32'd0);
        chk("rst_ram_adr_o", {15'd0, ram_adr_o}, 32'd0);
        chk("rst_ram_wr_o",  {31'd0, ram_wr_o}, 32'd0);
        chk("rst_ram_dat_o", {24'd0, ram_dat_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Table of single transactions, issued back-to-back as soon as the DUT is idle.
        a0 = 0;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].rwen, vecs[i].len, vecs[i].adr, vecs[i].wdat, a);
            if (i == 0) a0 = a;
            sb.push_back('{vecs[i].exp_dat, !vecs[i].rwen, a + vecs[i].lat});
            wait_done(30);
        end

        // Byte order, addresses and timing of the first word store.
        chk("wlog_size", (wlog.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (wlog.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("st_wr_cycle", wlog[k].cyc, a0 + 1 + k);
                chk("st_wr_adr",   {15'd0, wlog[k].adr}, 32'h100 + k);
            end
            chk("st_wr_bytes", {wlog[3].dat, wlog[2].dat, wlog[1].dat, wlog[0].dat}, 32'hDEADBEEF);
        end
        chk("wrap_mem", {mem[17'h00001], mem[17'h00000], mem[17'h1FFFF], mem[17'h1FFFE]}, 32'h11223344);

        // Flush during a word load: no ack, idle the following cycle.
        issue(1'b0, 3'd4, 17'h00100, 32'h0, a);
        tick();
        rob_br_flag = 1'b1;
        tick();
        rob_br_flag = 1'b0;
        chk("flush_rd_cycle", cyc, a + 3);
        chk("flush_rd_busy", {31'd0, busy_o}, 32'd0);
        repeat (8) tick();

        // Flush during a word store: store still completes and acks.
        wc0 = wlog.size();
        issue(1'b1, 3'd4, 17'h00300, 32'hCAFEF00D, a);
        sb.push_back('{32'h0, 1'b0, a + 5});
        tick();
        rob_br_flag = 1'b1;
        tick();
        rob_br_flag = 1'b0;
        wait_done(30);
        chk("flush_wr_count", wlog.size() - wc0, 4);
        chk("flush_wr_mem", mem_word(17'h00300), 32'hCAFEF00D);

        // en low for three cycles from A+2 of a word store.
        wc0 = wlog.size();
        issue(1'b1, 3'd4, 17'h00400, 32'h01020304, a);
        sb.push_back('{32'h0, 1'b0, a + 8});
        tick();
        en = 1'b0;
        tick(); tick(); tick();
        en = 1'b1;
        wait_done(30);
        chk("stall_wr_count", wlog.size() - wc0, 4);
        nstall = 0;
        for (int k = wc0; k < wlog.size(); k++)
            if (wlog[k].cyc >= a + 2 && wlog[k].cyc <= a + 4) nstall++;
        chk("stall_no_wr", nstall, 0);
        chk("stall_wr_mem", mem_word(17'h00400), 32'h01020304);

        // Reset in the middle of a word load, then a fresh byte load.
        issue(1'b0, 3'd4, 17'h00100, 32'h0, a);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_lsb_en_o",  {31'd0, lsb_en_o}, 32'd0);
        chk("mrst_lsb_dat_o", lsb_dat_o, 32'd0);
        chk("mrst_busy_o",    {31'd0, busy_o}, 32'd0);
        chk("mrst_ram_adr_o", {15'd0, ram_adr_o}, 32'd0);
        chk("mrst_ram_wr_o",  {31'd0, ram_wr_o}, 32'd0);
        issue(1'b0, 3'd1, 17'h00100, 32'h0, a);
        sb.push_back('{32'h000000EF, 1'b1, a + 3});
        wait_done(30);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-side memory controller; the responder for the load-store buffer's `dc_*` request port. It accepts one load or store request at a time and serialises it into byte accesses on the single-port, byte-wide RAM. It returns a one-cycle completion pulse, carrying load data, to the load-store buffer. It sits between the load-store buffer and the RAM/memory arbiter, and honours misprediction flush for loads.

## Interface
Parameters:
- `ADR_W`, default 17: RAM byte-address width (matches `RAM_ADR_W`).
- `DAT_W`, default 32: data word width.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: global ready; 0 freezes every register.
- `lsb_en_i`  in  1: request strobe, one cycle.
- `lsb_rwen_i`  in  1: 0 = read, 1 = write.
- `lsb_len_i`  in  3: byte count, 1/2/4.
- `lsb_adr_i`  in  ADR_W: base byte address.
- `lsb_dat_i`  in  DAT_W: store data, little-endian, low bytes used.
- `lsb_en_o`  out  1: completion pulse, one cycle.
- `lsb_dat_o`  out  DAT_W: load data, zero-extended; valid while `lsb_en_o`=1.
- `busy_o`  out  1: combinational, state != IDLE.
- `rob_br_flag`  in  1: misprediction flush.
- `ram_adr_o`  out  ADR_W: RAM byte address.
- `ram_wr_o`  out  1: RAM write enable.
- `ram_dat_o`  out  8: RAM write byte.
- `ram_dat_i`  in  8: RAM read byte; 1-cycle read latency.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - READ: issues addresses and captures returned bytes.
  - WRITE: writes one byte per cycle.
  - DONE: drives the `lsb_en_o` pulse.
- Length decode: `len[2]` gives 4 bytes, else `len[1]` gives 2, else 1.
- Accept (IDLE, `en`=1, `lsb_en_i`=1):
  - Latch address, length, data and direction.
  - Clear byte counters; go to READ or WRITE.
  - Requests arriving while `busy_o`=1 are ignored; the LSB must not issue them.
- READ:
  - Issue byte k at `ram_adr_o`=base+k with `ram_wr_o`=0, for k=0..n-1, one per cycle.
  - Byte k is captured from `ram_dat_i` the cycle after its address, into `lsb_dat_o[8k+7:8k]`.
  - Upper unused bytes are 0.
  - After the last capture, go to DONE.
- WRITE:
  - Drive `ram_adr_o`=base+k, `ram_dat_o`=`lsb_dat_i[8k+7:8k]`, `ram_wr_o`=1 for k=0..n-1, one per cycle.
  - Then go to DONE.
- DONE:
  - `lsb_en_o`=1 for one cycle; `ram_wr_o`=0.
  - Return to IDLE.
- Address arithmetic is modulo 2^ADR_W; base+k wraps past the top address.
- Flush (`rob_br_flag`=1):
  - In READ: abort; next state IDLE, no `lsb_en_o`, captured data discarded.
  - In WRITE/DONE: ignored; committed stores always complete and ack.
  - In IDLE, same cycle as a request: a read request is dropped; a write request is accepted.
- `en`=0:
  - All registers hold.
  - `ram_wr_o` is forced to 0 combinationally.
  - `lsb_en_o` is gated to 0 and its pulse is delivered after `en` returns.
  - The system guarantees the RAM is frozen by the same signal.
- Reset overrides everything, including mid-transaction:
  - State goes to IDLE; any in-flight write stops at a byte boundary.
  - All outputs are 0.
  - `ram_adr_o`=0, `lsb_dat_o`=0.
  - `busy_o`=0.

## Timing
- All outputs are registered except `busy_o` and the `en` gating.
- The request is accepted at cycle A. The first RAM address appears at A+1.
- Read of n bytes:
  - Addresses at A+1..A+n.
  - Captures at A+2..A+n+1.
  - `lsb_en_o` at A+n+2: A+3 for 1 byte, A+4 for 2, A+6 for 4.
- Write of n bytes:
  - `ram_wr_o`=1 at A+1..A+n.
  - `lsb_en_o` at A+n+1: A+2, A+3 or A+5.
- Back-to-back: the state is IDLE the cycle after `lsb_en_o`, so the next request can be accepted at A+n+3 (read) or A+n+2 (write).
- `ram_wr_o` is never 1 outside WRITE and is never 1 for two consecutive cycles at the same address.

## Test plan
- Word store, base 0x00100, data 0xDEADBEEF:
  - Bytes EF, BE, AD, DE written at 0x100..0x103 in cycles A+1..A+4.
  - `lsb_en_o` at A+5.
- Word load of the same address:
  - `lsb_dat_o`=0xDEADBEEF, `lsb_en_o` at A+6.
  - Half load at 0x102 returns 0x0000DEAD at A+4.
  - Byte load at 0x103 returns 0x000000DE at A+3.
- Wrap-around: word store at 0x1FFFE with data 0x11223344.
  - Bytes land at 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
  - A word load from 0x1FFFE reads back 0x11223344.
- Flush:
  - `rob_br_flag` at A+2 of a word load gives no `lsb_en_o`, and `busy_o`=0 at A+3.
  - `rob_br_flag` at A+2 of a word store still completes all 4 writes and acks at A+5.
- Stall: `en`=0 for 3 cycles starting A+2 of a word store.
  - No `ram_wr_o` during the stall; 4 writes total.
  - Ack at A+8; memory contents correct.
- Reset mid-read at A+3: next cycle all outputs 0, `busy_o`=0, and a new byte load succeeds.
